// File: rtl/traffic_pkg.sv
// Shared types and constants for the two-road intersection controller:
// lamp encodings, state codes and the per-state dwell lookup.
package traffic_pkg;

    // Lamp encodings, bit 0 = red, bit 1 = green, bit 2 = yellow.
    localparam logic [0:2] LAMP_RED    = 3'b100;
    localparam logic [0:2] LAMP_GREEN  = 3'b010;
    localparam logic [0:2] LAMP_YELLOW = 3'b001;
    localparam logic [0:2] LAMP_OFF    = 3'b000;

    // Controller states; the codes are exported on the phase port.
    typedef enum logic [2:0] {
        S_NS_GREEN  = 3'd0,
        S_NS_YELLOW = 3'd1,
        S_ALLRED_A  = 3'd2,
        S_EW_GREEN  = 3'd3,
        S_EW_YELLOW = 3'd4,
        S_ALLRED_B  = 3'd5,
        S_PED_WALK  = 3'd6,
        S_FLASH     = 3'd7
    } state_e;

    // Dwell of a state in ticks. FLASH has no dwell; 1 keeps the timer compare defined.
    function automatic int unsigned phase_dur(
        input state_e      st,
        input int unsigned green_t,
        input int unsigned yellow_t,
        input int unsigned allred_t,
        input int unsigned ped_t
    );
        int unsigned d;
        case (st)
            S_NS_GREEN,  S_EW_GREEN:  d = green_t;
            S_NS_YELLOW, S_EW_YELLOW: d = yellow_t;
            S_ALLRED_A,  S_ALLRED_B:  d = allred_t;
            S_PED_WALK:               d = ped_t;
            default:                  d = 32'd1;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/phase_timer.sv
// Phase dwell counter: counts enable pulses and flags the final tick of a
// phase of length dur. The owner clears it whenever the state changes.
module phase_timer #(
    parameter int CNT_W = 8
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             en,
    input  logic             clr,
    input  logic [CNT_W-1:0] dur,
    output logic             done
);

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: clear wins over advancing, otherwise hold.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + ONE;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Counter register with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done = en & (cnt_q == (dur - ONE));

endmodule

// File: rtl/traffic_intersection_ctrl.sv
// Two-road intersection controller: NS/EW green-yellow-allred cycle with a
// latched pedestrian walk phase and a flashing-yellow maintenance mode.
// All lamp/status outputs are registered from the next-state values, so
// they change on the same edge as the state.
module traffic_intersection_ctrl #(
    parameter int          CNT_W        = 8,
    parameter int unsigned GREEN_TICKS  = 20,
    parameter int unsigned YELLOW_TICKS = 4,
    parameter int unsigned ALLRED_TICKS = 2,
    parameter int unsigned PED_TICKS    = 10
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       tick_en,
    input  logic       ped_req,
    input  logic       flash_mode,
    output logic [0:2] light_ns,
    output logic [0:2] light_ew,
    output logic       walk,
    output logic       ped_ack,
    output logic       ped_pending,
    output logic [2:0] phase
);

    import traffic_pkg::*;

    localparam longint unsigned MAX_TICKS = (64'd1 << CNT_W) - 64'd1;

    if (GREEN_TICKS == 0 || YELLOW_TICKS == 0 || ALLRED_TICKS == 0 || PED_TICKS == 0 ||
        GREEN_TICKS > MAX_TICKS || YELLOW_TICKS > MAX_TICKS ||
        ALLRED_TICKS > MAX_TICKS || PED_TICKS > MAX_TICKS) begin : g_bad_ticks
        $error("traffic_intersection_ctrl: every *_TICKS must lie in 1 .. 2**CNT_W-1");
    end

    state_e           state_q, state_d;
    logic             blink_q, blink_d;
    logic             resume_ew_q, resume_ew_d;
    logic             pend_q, pend_d;
    logic             ack_q, ack_d;
    logic [0:2]       ns_q, ns_d;
    logic [0:2]       ew_q, ew_d;
    logic             walk_q, walk_d;
    logic             clr_s;
    logic             done_s;
    logic [CNT_W-1:0] dur_s;

    assign dur_s = CNT_W'(phase_dur(state_q, GREEN_TICKS, YELLOW_TICKS, ALLRED_TICKS, PED_TICKS));

    phase_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clock   (clock),
        .reset_n (reset_n),
        .en      (tick_en),
        .clr     (clr_s),
        .dur     (dur_s),
        .done    (done_s)
    );

    // Next-state, pedestrian latch and blink logic; flash beats timer expiry.
    always_comb begin
        state_d     = state_q;
        blink_d     = blink_q;
        resume_ew_d = resume_ew_q;
        clr_s       = 1'b0;

        // A request is taken only when nothing is already waiting.
        if (ped_req && !pend_q) begin
            pend_d = 1'b1;
            ack_d  = 1'b1;
        end else begin
            pend_d = pend_q;
            ack_d  = 1'b0;
        end

        if (flash_mode) begin
            state_d = S_FLASH;
            clr_s   = 1'b1;
            if (state_q != S_FLASH) begin
                blink_d = 1'b1;
            end else if (tick_en) begin
                blink_d = ~blink_q;
            end else begin
                blink_d = blink_q;
            end
        end else if (state_q == S_FLASH) begin
            // Leaving maintenance always passes through a full clearance.
            state_d = S_ALLRED_B;
            clr_s   = 1'b1;
            blink_d = 1'b0;
        end else if (done_s) begin
            clr_s = 1'b1;
            case (state_q)
                S_NS_GREEN:  state_d = S_NS_YELLOW;
                S_NS_YELLOW: state_d = S_ALLRED_A;
                S_EW_GREEN:  state_d = S_EW_YELLOW;
                S_EW_YELLOW: state_d = S_ALLRED_B;
                S_ALLRED_A: begin
                    if (pend_q) begin
                        state_d     = S_PED_WALK;
                        resume_ew_d = 1'b1;
                        pend_d      = 1'b0;
                    end else begin
                        state_d = S_EW_GREEN;
                    end
                end
                S_ALLRED_B: begin
                    if (pend_q) begin
                        state_d     = S_PED_WALK;
                        resume_ew_d = 1'b0;
                        pend_d      = 1'b0;
                    end else begin
                        state_d = S_NS_GREEN;
                    end
                end
                S_PED_WALK:  state_d = resume_ew_q ? S_EW_GREEN : S_NS_GREEN;
                default:     state_d = S_ALLRED_B;
            endcase
        end else begin
            clr_s = 1'b0;
        end
    end

    // Lamp decode from the next state so lamps land on the same edge as the state.
    always_comb begin
        walk_d = 1'b0;
        case (state_d)
            S_NS_GREEN:  begin ns_d = LAMP_GREEN;  ew_d = LAMP_RED;    end
            S_NS_YELLOW: begin ns_d = LAMP_YELLOW; ew_d = LAMP_RED;    end
            S_EW_GREEN:  begin ns_d = LAMP_RED;    ew_d = LAMP_GREEN;  end
            S_EW_YELLOW: begin ns_d = LAMP_RED;    ew_d = LAMP_YELLOW; end
            S_PED_WALK:  begin ns_d = LAMP_RED;    ew_d = LAMP_RED;    walk_d = 1'b1; end
            S_FLASH: begin
                ns_d = blink_d ? LAMP_YELLOW : LAMP_OFF;
                ew_d = blink_d ? LAMP_YELLOW : LAMP_OFF;
            end
            default:     begin ns_d = LAMP_RED;    ew_d = LAMP_RED;    end
        endcase
    end

    // State and output registers; reset parks the junction in all-red clearance.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q     <= S_ALLRED_B;
            blink_q     <= 1'b0;
            resume_ew_q <= 1'b0;
            pend_q      <= 1'b0;
            ack_q       <= 1'b0;
            ns_q        <= LAMP_RED;
            ew_q        <= LAMP_RED;
            walk_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            blink_q     <= blink_d;
            resume_ew_q <= resume_ew_d;
            pend_q      <= pend_d;
            ack_q       <= ack_d;
            ns_q        <= ns_d;
            ew_q        <= ew_d;
            walk_q      <= walk_d;
        end
    end

    assign light_ns    = ns_q;
    assign light_ew    = ew_q;
    assign walk        = walk_q;
    assign ped_ack     = ack_q;
    assign ped_pending = pend_q;
    assign phase       = state_q;

endmodule
